alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 32-bit combinational ALU. Operands and opcode are accepted over a valid/ready input port and the result, with status flags, is held in an output register until it is consumed. The block adds an iterative unsigned multiply, taking WIDTH cycles, in the opcode slot the previous ALU left unused. It sits between an operand-issue stage and a writeback stage that may stall.

## Interface
- WIDTH, 32: operand/result width; multiple of 8, ≥ 8.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept; combinational from state and out_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- opcode  input  4  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- flag_zero, flag_carry, flag_overflow, flag_negative  output  1 each  registered status.
- busy  output  1  high in MUL state.

## Operation
- All outputs are registered. Outputs are held stable while out_valid=1 and out_ready=0.
- Opcodes:
  - 0000: 0
  - 0001: A
  - 0010: B
  - 0011: ~A
  - 0100: A+1
  - 0101: B+1
  - 0110: A*B, low WIDTH bits, unsigned, iterative
  - 0111: A+B
  - 1000: A−B
  - 1001: A&B
  - 1010: A|B
  - 1011: A^B
  - 1100: A<<B
  - 1101: A>>B, logical
  - 1110: byte reverse, byte 0 ↔ byte N−1
  - 1111: parity, {zeros, ^A}
- Shifts: if B ≥ WIDTH, the result is 0. The full B is compared, not truncated.
- Flags:
  - zero = (result==0).
  - negative = result[WIDTH−1].
  - carry:
    - Add/inc: carry-out.
    - Sub: borrow (A<B unsigned).
    - Mul: 1 if the upper WIDTH bits of the full product are nonzero.
    - Otherwise 0.
  - overflow: signed overflow for add/inc/sub; 0 for all other opcodes.
- The operands and opcode are captured at acceptance. Later changes on a/b/opcode have no effect.
- States:
  - IDLE:
    - in_ready=1.
    - On accept with a non-mul opcode, go to DONE with the result computed.
    - On accept with mul, go to MUL: load multiplicand/multiplier, clear the accumulator, counter=0.
  - MUL:
    - Each cycle, add the shifted multiplicand if the current multiplier bit is 1. Track the high half for carry.
    - Increment the counter. When the counter reaches WIDTH−1, go to DONE.
    - busy=1 and in_ready=0 throughout.
  - DONE:
    - out_valid=1.
    - If out_ready=1 and in_valid=1: accept the new operation in the same cycle (in_ready=1). Go to DONE (non-mul) or MUL.
    - If out_ready=1 and in_valid=0: go to IDLE.
    - If out_ready=0: hold, in_ready=0.
- Reset at any time (including mid-multiply) aborts the operation with no partial result emitted. Reset values:
  - state IDLE
  - out_valid=0, busy=0
  - result=0, all flags=0
  - in_ready=1 after reset releases

## Timing
- Acceptance = rising edge with in_valid & in_ready.
- Non-mul: out_valid rises at the edge that accepts the operation, so the result is visible from the next cycle (1-cycle latency).
- Mul: out_valid rises WIDTH edges after acceptance. The full operation occupies WIDTH+1 cycles including the DONE cycle.
- Back-to-back non-mul ops with out_ready held at 1 sustain one result per cycle.
- A result is consumed at the edge where out_valid & out_ready are both 1.
- in_ready depends combinationally on out_ready only in DONE. There is no combinational path from a, b or opcode to any output.

## Test plan
- Reset release, then accept opcode 0111 with A=0xFFFFFFFF, B=1 → next cycle: result=0, zero=1, carry=1, overflow=0.
- Opcode 0110 with A=0x0001_0000, B=0x0001_0000 (WIDTH=32) → busy for 32 cycles, then result=0, carry=1. Also A=12345, B=678 → result=8369910, carry=0.
- Opcode 1000 with A=0x80000000, B=1 → result=0x7FFFFFFF, overflow=1, carry=0. Opcode 1100 with B=32 → result=0. Opcode 1110 with A=0x11223344 → result=0x44332211.
- Stall: hold out_ready=0 for 5 cycles after a result, with new in_valid pending → in_ready=0, result/flags stable. Raise out_ready → new op accepted the same edge, and its result appears next cycle.
- Assert rst at cycle 10 of a multiply → out_valid=0, busy=0, result=0 immediately. After release, in_ready=1 and no stale result appears.
- WIDTH=8 instance: opcode 1111 with A=0x07 → result=0x01. Opcode 0110 with A=16, B=16 → result=0, carry=1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with an iterative unsigned multiply. Results and flags are held
// in output registers until the writeback stage consumes them.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             flag_negative,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [3:0] {
    OP_ZERO = 4'h0, OP_A    = 4'h1, OP_B   = 4'h2, OP_NOT  = 4'h3,
    OP_INCA = 4'h4, OP_INCB = 4'h5, OP_MUL = 4'h6, OP_ADD  = 4'h7,
    OP_SUB  = 4'h8, OP_AND  = 4'h9, OP_OR  = 4'hA, OP_XOR  = 4'hB,
    OP_SHL  = 4'hC, OP_SHR  = 4'hD, OP_REV = 4'hE, OP_PAR  = 4'hF
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e             state, state_next;
  logic               accept, is_mul, mul_last;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf;
  logic [2*WIDTH-1:0] acc, acc_next, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign accept   = in_valid & in_ready;
  assign is_mul   = (op_e'(opcode) == OP_MUL);
  assign mul_last = (cnt == CW'(WIDTH-1));
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  end

  // Single-cycle datapath for every opcode except multiply.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_e'(opcode))
      OP_A:    alu_res = a;
      OP_B:    alu_res = b;
      OP_NOT:  alu_res = ~a;
      OP_INCA: begin
        {alu_carry, alu_res} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        alu_ovf = ~a[WIDTH-1] & alu_res[WIDTH-1];
      end
      OP_INCB: begin
        {alu_carry, alu_res} = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
        alu_ovf = ~b[WIDTH-1] & alu_res[WIDTH-1];
      end
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = a - b;
        alu_carry = (a < b);
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = (b >= WIDTH_V) ? '0 : (a << b);
      OP_SHR:  alu_res = (b >= WIDTH_V) ? '0 : (a >> b);
      OP_REV: begin
        for (int i = 0; i < WIDTH/8; i++) alu_res[8*i +: 8] = a[WIDTH-8-8*i +: 8];
      end
      OP_PAR:  alu_res = {{(WIDTH-1){1'b0}}, ^a};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_next = S_DONE;
      S_DONE: begin
        if (out_ready) state_next = in_valid ? (is_mul ? S_MUL : S_DONE) : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // out_valid and busy are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= (state_next == S_DONE);
      busy      <= (state_next == S_MUL);
    end
  end

  // NOTE: multiplier working registers carry no reset; they are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result        <= '0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      flag_negative <= 1'b0;
    end else if (accept && !is_mul) begin
      result        <= alu_res;
      flag_zero     <= (alu_res == '0);
      flag_carry    <= alu_carry;
      flag_overflow <= alu_ovf;
      flag_negative <= alu_res[WIDTH-1];
    end else if ((state == S_MUL) && mul_last) begin
      result        <= acc_next[WIDTH-1:0];
      flag_zero     <= (acc_next[WIDTH-1:0] == '0);
      flag_carry    <= |acc_next[2*WIDTH-1:WIDTH];
      flag_overflow <= 1'b0;
      flag_negative <= acc_next[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized, self-checking bench for alu_seq at WIDTH=32 and WIDTH=8 against
// an arithmetic reference model.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic z, c, v, n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  logic [3:0]  opcode;
  logic        fz, fc, fv, fn;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  opcode8;
  logic        fz8, fc8, fv8, fn8;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_zero(fz), .flag_carry(fc), .flag_overflow(fv),
    .flag_negative(fn), .busy(busy)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .opcode(opcode8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag_zero(fz8), .flag_carry(fc8), .flag_overflow(fv8),
    .flag_negative(fn8), .busy(busy8)
  );

  // Reference model: plain 64-bit arithmetic on values masked to w bits.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [31:0] av, input logic [31:0] bv);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, s, smax, smin;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    ua   = 64'(av) & mask;
    ub   = 64'(bv) & mask;
    smax = longint'(mask >> 1);
    smin = -smax - 1;
    sa   = (ua > (mask >> 1)) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
    sb   = (ub > (mask >> 1)) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
    e = '0;
    r = 0;
    s = 0;
    case (op)
      4'h0: r = 0;
      4'h1: r = ua;
      4'h2: r = ub;
      4'h3: r = ~ua;
      4'h4: begin r = ua + 1; e.c = (r > mask); e.v = (sa + 1 > smax); end
      4'h5: begin r = ub + 1; e.c = (r > mask); e.v = (sb + 1 > smax); end
      4'h6: begin r = ua * ub; e.c = (r > mask); end
      4'h7: begin r = ua + ub; e.c = (r > mask); s = sa + sb; e.v = (s > smax) || (s < smin); end
      4'h8: begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s > smax) || (s < smin); end
      4'h9: r = ua & ub;
      4'hA: r = ua | ub;
      4'hB: r = ua ^ ub;
      4'hC: r = (ub >= 64'(w)) ? 0 : (ua << ub);
      4'hD: r = (ub >= 64'(w)) ? 0 : (ua >> ub);
      4'hE: for (int i = 0; i < w/8; i++) r = r | (((ua >> (8*i)) & 64'hFF) << (8*(w/8-1-i)));
      default: r = 64'($countones(ua) & 1);
    endcase
    r = r & mask;
    e.res = 32'(r);
    e.z   = (r == 0);
    e.n   = r[w-1];
    return e;
  endfunction

  // One operation through the 32-bit DUT, out_ready held low until the result is checked.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int edges, busy_cnt;
    e = model(32, op, av, bv);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready op=%h in_ready=%b expected 1", op, in_ready);
    end
    in_valid = 1'b1; opcode = op; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; opcode = 4'($urandom);
    edges = 0; busy_cnt = 0;
    while (!out_valid && edges < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != ((op == 4'h6) ? 32 : 0)) begin
      errors++;
      $display("FAIL latency op=%h edges=%0d expected %0d", op, edges, (op == 4'h6) ? 32 : 0);
    end
    if (op == 4'h6) begin
      checks++;
      if (busy_cnt != 32) begin
        errors++;
        $display("FAIL busy_cycles got=%0d expected 32", busy_cnt);
      end
    end
    checks++;
    if ({result, fz, fc, fv, fn} !== {e.res, e.z, e.c, e.v, e.n}) begin
      errors++;
      $display("FAIL result op=%h a=%h b=%h got=%h zcvn=%b%b%b%b expected=%h zcvn=%b%b%b%b",
               op, av, bv, result, fz, fc, fv, fn, e.res, e.z, e.c, e.v, e.n);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume op=%h out_valid=%b expected 0", op, out_valid);
    end
  endtask

  task automatic run_op8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    int edges;
    e = model(8, op, {24'b0, av}, {24'b0, bv});
    @(negedge clk);
    in_valid8 = 1'b1; opcode8 = op; a8 = av; b8 = bv;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    edges = 0;
    while (!out_valid8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != ((op == 4'h6) ? 8 : 0) ||
        {result8, fz8, fc8, fv8, fn8} !== {e.res[7:0], e.z, e.c, e.v, e.n}) begin
      errors++;
      $display("FAIL w8_result op=%h a=%h b=%h got=%h zcvn=%b%b%b%b edges=%0d expected=%h zcvn=%b%b%b%b",
               op, av, bv, result8, fz8, fc8, fv8, fn8, edges, e.res[7:0], e.z, e.c, e.v, e.n);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, result, fz, fc, fv, fn} !== '0 ||
        {out_valid8, busy8, result8, fz8, fc8, fv8, fn8} !== '0) begin
      errors++;
      $display("FAIL reset_state out_valid=%b busy=%b result=%h flags=%b%b%b%b expected all 0",
               out_valid, busy, result, fz, fc, fv, fn);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready in_ready=%b in_ready8=%b expected 1", in_ready, in_ready8);
    end
  endtask

  task automatic test_directed();
    run_op(4'h7, 32'hFFFF_FFFF, 32'h1);
    run_op(4'h6, 32'h0001_0000, 32'h0001_0000);
    run_op(4'h6, 32'd12345, 32'd678);
    run_op(4'h8, 32'h8000_0000, 32'h1);
    run_op(4'hC, 32'h1234_5678, 32'd32);
    run_op(4'hC, 32'h1234_5678, 32'h0000_0100);
    run_op(4'hD, 32'hF000_0000, 32'h8000_0001);
    run_op(4'hD, 32'hF000_0000, 32'd31);
    run_op(4'hE, 32'h1122_3344, 32'h0);
    run_op(4'h4, 32'h7FFF_FFFF, 32'h0);
    run_op(4'h5, 32'h0, 32'hFFFF_FFFF);
    run_op(4'hF, 32'h0000_0007, 32'h0);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] av, bv;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 5))
        0: av = 32'h7FFF_FFFF;
        1: av = 32'h8000_0000;
        2: av = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, av, bv);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] op;
    logic [31:0] av, bv;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h6) op = 4'h7;
      av = $urandom; bv = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 35)) : $urandom;
      e = model(32, op, av, bv);
      in_valid = 1'b1; opcode = op; a = av; b = bv;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
          {result, fz, fc, fv, fn} !== {e.res, e.z, e.c, e.v, e.n}) begin
        errors++;
        $display("FAIL b2b i=%0d op=%h out_valid=%b in_ready=%b got=%h expected=%h",
                 i, op, out_valid, in_ready, result, e.res);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    exp_t e1, e2;
    out_ready = 1'b0;
    e1 = model(32, 4'hB, 32'hA5A5_0F0F, 32'h0FF0_F00F);
    e2 = model(32, 4'h7, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'hB; a = 32'hA5A5_0F0F; b = 32'h0FF0_F00F;
    @(posedge clk); #1;
    opcode = 4'h7; a = 32'h7FFF_FFFF; b = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {result, fz, fc, fv, fn} !== {e1.res, e1.z, e1.c, e1.v, e1.n}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d in_ready=%b out_valid=%b result=%h expected in_ready=0 result=%h",
                 i, in_ready, out_valid, result, e1.res);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {result, fz, fc, fv, fn} !== {e2.res, e2.z, e2.c, e2.v, e2.n}) begin
      errors++;
      $display("FAIL stall_next out_valid=%b got=%h zcvn=%b%b%b%b expected=%h zcvn=%b%b%b%b",
               out_valid, result, fz, fc, fv, fn, e2.res, e2.z, e2.c, e2.v, e2.n);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mul_reset();
    int stale;
    run_op(4'h1, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'h6; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mulrst_busy busy=%b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, result, fz, fc, fv, fn} !== '0) begin
      errors++;
      $display("FAIL mulrst_clear out_valid=%b busy=%b result=%h expected all 0", out_valid, busy, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mulrst_ready in_ready=%b expected 1", in_ready);
    end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL mulrst_stale cycles_with_output=%0d expected 0", stale);
    end
  endtask

  task automatic test_width8();
    run_op8(4'hF, 8'h07, 8'h00);
    run_op8(4'h6, 8'd16, 8'd16);
    run_op8(4'hE, 8'h5A, 8'h00);
    run_op8(4'hC, 8'h81, 8'd8);
    for (int i = 0; i < 30; i++) run_op8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 12)));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; opcode8 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_stall();
    test_mul_reset();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
